mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// Iterative RV64M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// with zero-divisor and signed-overflow cases resolved in the accept cycle.
module mdu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic        req_w,
    input  logic [63:0] req_src1,
    input  logic [63:0] req_src2,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_result,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e       state_q, state_d;
    logic [6:0]   cnt_q, cnt_d;
    logic [63:0]  result_q, result_d;
    logic [2:0]   op_q, op_d;
    logic         w_q, w_d;
    logic [127:0] acc_q, acc_d;
    logic [63:0]  opb_q, opb_d;
    logic         negp_q, negp_d, negr_q, negr_d;

    logic         accept;
    logic         sign_a, sign_b, a_neg, b_neg;
    logic [63:0]  a_ext, b_ext, a_mag, b_mag, dividend;
    logic         div0, ovf, special;
    logic [63:0]  spec_result;

    logic [64:0]  mul_sum, mul_hi;
    logic         div_ge;
    logic [63:0]  div_sub;
    logic [127:0] step, prod;
    logic [63:0]  quo, rem, fin;

    assign req_ready   = (state_q == StIdle) && !flush;
    assign accept      = req_valid && req_ready;
    assign resp_valid  = (state_q == StDone);
    assign busy        = (state_q != StIdle);
    assign resp_result = result_q;

    // Operand conditioning and special-case detection for the op being offered.
    always_comb begin
        sign_a = (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd4) || (req_op == 3'd6);
        sign_b = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
        a_ext  = req_src1;
        b_ext  = req_src2;
        if (req_w) begin
            a_ext = sign_a ? {{32{req_src1[31]}}, req_src1[31:0]} : {32'd0, req_src1[31:0]};
            b_ext = sign_b ? {{32{req_src2[31]}}, req_src2[31:0]} : {32'd0, req_src2[31:0]};
        end
        a_neg = sign_a && a_ext[63];
        b_neg = sign_b && b_ext[63];
        a_mag = a_neg ? (~a_ext + 64'd1) : a_ext;
        b_mag = b_neg ? (~b_ext + 64'd1) : b_ext;

        dividend = req_w ? {{32{req_src1[31]}}, req_src1[31:0]} : req_src1;
        if (req_w) begin
            div0 = (req_src2[31:0] == 32'd0);
            ovf  = sign_b && (req_src1[31:0] == 32'h8000_0000) && (req_src2[31:0] == '1);
        end else begin
            div0 = (req_src2 == 64'd0);
            ovf  = sign_b && (req_src1 == 64'h8000_0000_0000_0000) && (req_src2 == '1);
        end
        special = req_op[2] && (div0 || ovf);
        if (!req_op[1]) spec_result = div0 ? '1 : dividend;
        else            spec_result = div0 ? dividend : 64'd0;
    end

    // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum = {1'b0, acc_q[127:64]} + {1'b0, opb_q};
        mul_hi  = acc_q[0] ? mul_sum : {1'b0, acc_q[127:64]};
        div_ge  = (acc_q[127:63] >= {1'b0, opb_q});
        div_sub = acc_q[126:63] - opb_q;
        if (op_q[2]) step = div_ge ? {div_sub, acc_q[62:0], 1'b1} : {acc_q[126:0], 1'b0};
        else         step = {mul_hi, acc_q[63:1]};

        prod = negp_q ? (~step + 128'd1) : step;
        quo  = negp_q ? (~step[63:0] + 64'd1) : step[63:0];
        rem  = negr_q ? (~step[127:64] + 64'd1) : step[127:64];
        unique case (op_q)
            3'd0:       fin = w_q ? {{32{prod[63]}}, prod[63:32]} : prod[63:0];
            3'd4, 3'd5: fin = w_q ? {{32{quo[31]}}, quo[31:0]} : quo;
            3'd6, 3'd7: fin = w_q ? {{32{rem[31]}}, rem[31:0]} : rem;
            default:    fin = prod[127:64];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        op_d     = op_q;
        w_d      = w_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        negp_d   = negp_q;
        negr_d   = negr_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d   = req_op;
                    w_d    = req_w;
                    negp_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    if (special) begin
                        state_d  = StDone;
                        result_d = spec_result;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = req_w ? 7'd32 : 7'd64;
                        if (req_op[2]) begin
                            // W dividend is pre-aligned so its MSB leaves first.
                            acc_d = {64'd0, req_w ? {a_mag[31:0], 32'd0} : a_mag};
                            opb_d = b_mag;
                        end else begin
                            acc_d = {64'd0, b_mag};
                            opb_d = a_mag;
                        end
                    end
                end
            end
            StBusy: begin
                acc_d = step;
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    state_d  = StDone;
                    result_d = fin;
                end
            end
            StDone: begin
                if (resp_ready) begin
                    state_d  = StIdle;
                    result_d = 64'd0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d  = StIdle;
            cnt_d    = 7'd0;
            result_d = 64'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 7'd0;
            result_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q   <= op_d;
        w_q    <= w_d;
        acc_q  <= acc_d;
        opb_q  <= opb_d;
        negp_q <= negp_d;
        negr_q <= negr_d;
    end

endmodule
